// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
//
// Multi-cycle execute sequencer. It takes one decoded ALU instruction at a
// time and steps it through the shared 16-bit ALU in four states:
//   IDLE : accept an instruction and register the register-file read addresses
//   READ : register-file data arrives; latch operand A and the formed operand B
//   EXEC : ALU inputs are stable; capture the result and the five flags
//   WB   : write the result back (CMP never writes) and optionally load the PSR
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready    decode handshake (ready only in IDLE)
//   i_op, i_imm_mode, i_imm,
//   i_rdest, i_rsrc,
//   i_use_carry, i_set_flags     decoded instruction fields
//   rf_raddr_a/b, rf_rdata_a/b   register-file read port (data one cycle later)
//   rf_we, rf_waddr, rf_wdata    register-file write port
//   alu_a, alu_b, alu_op,
//   alu_imm_mode, alu_carry_in,
//   alu_update_flags             ALU controls, held stable from EXEC onward
//   alu_result, alu_carry, alu_low,
//   alu_flag, alu_zero,
//   alu_negative                 combinational ALU outputs
//   psr                          processor status {N, Z, F, L, C}
//   done                         one-cycle pulse when an instruction retires
// -----------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        i_op,
  input  logic              i_imm_mode,
  input  logic [7:0]        i_imm,
  input  logic [REG_AW-1:0] i_rdest,
  input  logic [REG_AW-1:0] i_rsrc,
  input  logic              i_use_carry,
  input  logic              i_set_flags,

  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [15:0]       rf_rdata_a,
  input  logic [15:0]       rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [15:0]       rf_wdata,

  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_imm_mode,
  output logic              alu_carry_in,
  output logic              alu_update_flags,
  input  logic [15:0]       alu_result,
  input  logic              alu_carry,
  input  logic              alu_low,
  input  logic              alu_flag,
  input  logic              alu_zero,
  input  logic              alu_negative,

  output logic [4:0]        psr,
  output logic              done
);

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_LSH = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_LUI = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t              state_q;
  logic                ready_q;

  // Instruction register, loaded in the accept cycle only.
  logic [3:0]          instrOp_q;
  logic                instrImmMode_q;
  logic [7:0]          instrImm_q;
  logic [REG_AW-1:0]   instrRdest_q;
  logic                instrUseCarry_q;
  logic                instrSetFlags_q;

  logic [REG_AW-1:0]   raddrA_q;
  logic [REG_AW-1:0]   raddrB_q;

  // Operand registers double as the ALU input drivers, so the ALU sees
  // stable values for the whole of EXEC.
  logic [15:0]         aluA_q;
  logic [15:0]         aluB_q;
  logic [3:0]          aluOp_q;
  logic                aluImmMode_q;
  logic                aluCarryIn_q;
  logic                aluUpdFlags_q;

  // Holding registers for the ALU result and flags captured at end of EXEC.
  logic [15:0]         result_q;
  logic [4:0]          flags_q;

  logic                rfWe_q;
  logic                done_q;
  logic [4:0]          psr_q;

  logic [15:0]         operandB_d;
  logic                updateFlags_d;
  logic                carryIn_d;

  // Operand B formation. Arithmetic and shift opcodes treat the immediate as
  // signed, logical moves treat it as unsigned, and LUI places it in the
  // upper byte. Unknown opcodes fall back to zero extension.
  always_comb begin
    operandB_d = rf_rdata_b;
    if (instrImmMode_q) begin
      case (instrOp_q)
        OP_ADD, OP_SUB, OP_CMP, OP_LSH: operandB_d = {{8{instrImm_q[7]}}, instrImm_q};
        OP_AND, OP_OR, OP_XOR, OP_MOV:  operandB_d = {8'h00, instrImm_q};
        OP_LUI:                         operandB_d = {instrImm_q, 8'h00};
        default:                        operandB_d = {8'h00, instrImm_q};
      endcase
    end
  end

  // MOV and LUI never touch the PSR, whatever the decoder asked for. The
  // carry-in samples the PSR at the end of READ, which is after the previous
  // instruction's WB, so ADDC/SUBC chains see the freshly written carry.
  always_comb begin
    updateFlags_d = instrSetFlags_q && (instrOp_q != OP_MOV) && (instrOp_q != OP_LUI);
    carryIn_d     = instrUseCarry_q & psr_q[0];
  end

  // Sequencer. One always_ff owns the state and every registered output. A
  // reset at any point drops back to IDLE; since rf_we, done and the PSR load
  // only happen from EXEC/WB, an aborted instruction leaves no trace.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      ready_q         <= 1'b1;
      instrOp_q       <= 4'h0;
      instrImmMode_q  <= 1'b0;
      instrImm_q      <= 8'h00;
      instrRdest_q    <= '0;
      instrUseCarry_q <= 1'b0;
      instrSetFlags_q <= 1'b0;
      raddrA_q        <= '0;
      raddrB_q        <= '0;
      aluA_q          <= 16'h0000;
      aluB_q          <= 16'h0000;
      aluOp_q         <= 4'h0;
      aluImmMode_q    <= 1'b0;
      aluCarryIn_q    <= 1'b0;
      aluUpdFlags_q   <= 1'b0;
      result_q        <= 16'h0000;
      flags_q         <= 5'b0;
      rfWe_q          <= 1'b0;
      done_q          <= 1'b0;
      psr_q           <= 5'b0;
    end else begin
      rfWe_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instrOp_q       <= i_op;
            instrImmMode_q  <= i_imm_mode;
            instrImm_q      <= i_imm;
            instrRdest_q    <= i_rdest;
            instrUseCarry_q <= i_use_carry;
            instrSetFlags_q <= i_set_flags;
            raddrA_q        <= i_rdest;
            raddrB_q        <= i_rsrc;
            ready_q         <= 1'b0;
            state_q         <= READ;
          end
        end
        READ: begin
          aluA_q        <= rf_rdata_a;
          aluB_q        <= operandB_d;
          aluOp_q       <= instrOp_q;
          aluImmMode_q  <= instrImmMode_q;
          aluCarryIn_q  <= carryIn_d;
          aluUpdFlags_q <= updateFlags_d;
          state_q       <= EXEC;
        end
        EXEC: begin
          result_q <= alu_result;
          flags_q  <= {alu_negative, alu_zero, alu_flag, alu_low, alu_carry};
          rfWe_q   <= (instrOp_q != OP_CMP);
          done_q   <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          if (aluUpdFlags_q) begin
            psr_q <= flags_q;
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready      = ready_q;
  assign rf_raddr_a       = raddrA_q;
  assign rf_raddr_b       = raddrB_q;
  assign rf_we            = rfWe_q;
  assign rf_waddr         = instrRdest_q;
  assign rf_wdata         = result_q;
  assign alu_a            = aluA_q;
  assign alu_b            = aluB_q;
  assign alu_op           = aluOp_q;
  assign alu_imm_mode     = aluImmMode_q;
  assign alu_carry_in     = aluCarryIn_q;
  assign alu_update_flags = aluUpdFlags_q;
  assign psr              = psr_q;
  assign done             = done_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//
// Drives alu_exec_ctrl with a small register-file model and a behavioural ALU.
// Each accepted instruction pushes its expected retirement onto a queue; a
// monitor pops and compares when done pulses, then checks the PSR one cycle
// later.
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  i_op;
  logic        i_imm_mode;
  logic [7:0]  i_imm;
  logic [3:0]  i_rdest;
  logic [3:0]  i_rsrc;
  logic        i_use_carry;
  logic        i_set_flags;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [15:0] rf_rdata_a;
  logic [15:0] rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_imm_mode;
  logic        alu_carry_in;
  logic        alu_update_flags;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_low;
  logic        alu_flag;
  logic        alu_zero;
  logic        alu_negative;
  logic [4:0]  psr;
  logic        done;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  alu_exec_ctrl #(.REG_AW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .i_op(i_op), .i_imm_mode(i_imm_mode), .i_imm(i_imm),
    .i_rdest(i_rdest), .i_rsrc(i_rsrc),
    .i_use_carry(i_use_carry), .i_set_flags(i_set_flags),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_imm_mode(alu_imm_mode), .alu_carry_in(alu_carry_in),
    .alu_update_flags(alu_update_flags),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_low(alu_low),
    .alu_flag(alu_flag), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .psr(psr), .done(done)
  );

  // Clock and a free-running cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: the DUT registers the read address, so data read from that
  // address is valid during READ. Preloaded once while memLoad is high.
  logic [15:0] mem [16];
  logic        memLoad = 1'b1;

  function automatic logic [15:0] initVal(input int i);
    case (i)
      1:       return 16'hFFFF;
      2:       return 16'h0001;
      3:       return 16'h0005;
      5:       return 16'h0001;
      8:       return 16'h1234;
      9:       return 16'h00F0;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 16; i++) mem[i] <= initVal(i);
    end else if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata_a = mem[rf_raddr_a];
  assign rf_rdata_b = mem[rf_raddr_b];

  // Behavioural ALU. Returns {N, Z, F, L, C, result[15:0]}.
  function automatic logic [20:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic c, l, f, z, n;
    s = '0; r = '0; c = 1'b0; l = 1'b0; f = 1'b0;
    case (op)
      4'b0101: begin
        s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        r = s[15:0]; c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b1001: begin
        s = {1'b0, a} - {1'b0, b} - {16'b0, cin};
        r = s[15:0]; c = s[16];
        f = (a[15] != b[15]) && (r[15] != a[15]);
        l = (a < b);
      end
      4'b1011: begin r = a - b; l = (a < b); end
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: r = a ^ b;
      4'b0100: r = b[15] ? (a >> 1) : (a << b[3:0]);
      4'b1101, 4'b1111: r = b;
      default: r = '0;
    endcase
    z = (r == 16'h0000);
    n = r[15];
    if (op == 4'b1011) begin
      z = (a == b);
      n = ($signed(a) < $signed(b));
    end
    return {n, z, f, l, c, r};
  endfunction

  logic [20:0] aluOut;
  assign aluOut       = aluModel(alu_a, alu_b, alu_op, alu_carry_in);
  assign alu_result   = aluOut[15:0];
  assign alu_carry    = aluOut[16];
  assign alu_low      = aluOut[17];
  assign alu_flag     = aluOut[18];
  assign alu_zero     = aluOut[19];
  assign alu_negative = aluOut[20];

  // Test vector record: instruction fields plus the expected retirement.
  typedef struct {
    logic [3:0]  op;
    logic        immMode;
    logic [7:0]  imm;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic        useCarry;
    logic        setFlags;
    logic        expWe;
    logic [15:0] expWdata;
    logic [15:0] expAluB;
    logic        expCin;
    logic        expUpd;
    logic [4:0]  expPsr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] aluB;
    logic        immMode;
    logic        cin;
    logic        upd;
    logic [4:0]  psr;
    int          accCyc;
  } sb_t;

  sb_t  sbQ[$];
  sb_t  cur;
  logic psrPend = 1'b0;
  logic [4:0] psrExp = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic sb_t toEntry(input vec_t v, input int acc);
    sb_t e;
    e.we = v.expWe; e.waddr = v.rdest; e.wdata = v.expWdata; e.aluB = v.expAluB;
    e.immMode = v.immMode; e.cin = v.expCin; e.upd = v.expUpd; e.psr = v.expPsr;
    e.accCyc = acc;
    return e;
  endfunction

  // Retirement monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (psrPend) begin
      checkOutput("psrAfterWb", {27'b0, psr}, {27'b0, psrExp});
      psrPend <= 1'b0;
    end
    if (rf_we && !done) checkOutput("rfWeWithoutDone", {31'b0, rf_we}, 32'd0);
    if (done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedRetire", 32'd1, 32'd0);
      end else begin
        cur = sbQ.pop_front();
        checkOutput("rfWe", {31'b0, rf_we}, {31'b0, cur.we});
        if (cur.we) begin
          checkOutput("rfWaddr", {28'b0, rf_waddr}, {28'b0, cur.waddr});
          checkOutput("rfWdata", {16'b0, rf_wdata}, {16'b0, cur.wdata});
        end
        checkOutput("aluB", {16'b0, alu_b}, {16'b0, cur.aluB});
        checkOutput("aluImmMode", {31'b0, alu_imm_mode}, {31'b0, cur.immMode});
        checkOutput("aluCarryIn", {31'b0, alu_carry_in}, {31'b0, cur.cin});
        checkOutput("aluUpdFlags", {31'b0, alu_update_flags}, {31'b0, cur.upd});
        checkOutput("retireLatency", cyc - cur.accCyc, 32'd2);
        psrExp  <= cur.psr;
        psrPend <= 1'b1;
      end
    end
  end

  // Drive one instruction once the controller is ready, then release valid.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    for (int w = 0; w < 20 && !instr_ready; w++) @(negedge clk);
    checkOutput("readyBeforeIssue", {31'b0, instr_ready}, 32'd1);
    i_op = v.op; i_imm_mode = v.immMode; i_imm = v.imm;
    i_rdest = v.rdest; i_rsrc = v.rsrc;
    i_use_carry = v.useCarry; i_set_flags = v.setFlags;
    instr_valid = 1'b1;
    sbQ.push_back(toEntry(v, cyc + 1));
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 40 && (sbQ.size() != 0 || psrPend); w++) @(negedge clk);
    checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
  endtask

  vec_t vecs[12];
  vec_t hv;
  int   accepts;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // op, immMode, imm, rdest, rsrc, useCarry, setFlags, expWe, expWdata, expAluB, expCin, expUpd, expPsr
    vecs[0]  = '{4'b0101, 1'b0, 8'h00, 4'd1,  4'd2, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 5'b01001};
    vecs[1]  = '{4'b0101, 1'b0, 8'h00, 4'd6,  4'd7, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b1, 5'b00000};
    vecs[2]  = '{4'b1001, 1'b1, 8'hFF, 4'd3,  4'd0, 1'b0, 1'b1, 1'b1, 16'h0006, 16'hFFFF, 1'b0, 1'b1, 5'b00011};
    vecs[3]  = '{4'b1011, 1'b0, 8'h00, 4'd4,  4'd5, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, 5'b10010};
    vecs[4]  = '{4'b1111, 1'b1, 8'hAB, 4'd9,  4'd0, 1'b0, 1'b1, 1'b1, 16'hAB00, 16'hAB00, 1'b0, 1'b0, 5'b10010};
    vecs[5]  = '{4'b1101, 1'b1, 8'h80, 4'd10, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0, 5'b10010};
    vecs[6]  = '{4'b0001, 1'b1, 8'hF0, 4'd8,  4'd0, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h00F0, 1'b0, 1'b1, 5'b00000};
    vecs[7]  = '{4'b0011, 1'b0, 8'h00, 4'd8,  4'd8, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0030, 1'b0, 1'b1, 5'b01000};
    vecs[8]  = '{4'b0010, 1'b1, 8'h80, 4'd2,  4'd0, 1'b0, 1'b1, 1'b1, 16'h0081, 16'h0080, 1'b0, 1'b1, 5'b00000};
    vecs[9]  = '{4'b0101, 1'b1, 8'hFE, 4'd5,  4'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 5'b00000};
    vecs[10] = '{4'b0100, 1'b1, 8'h03, 4'd2,  4'd0, 1'b0, 1'b1, 1'b1, 16'h0408, 16'h0003, 1'b0, 1'b1, 5'b00000};
    vecs[11] = '{4'b1001, 1'b0, 8'h00, 4'd4,  4'd5, 1'b1, 1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 5'b00011};

    reset_n = 1'b0; instr_valid = 1'b0;
    i_op = '0; i_imm_mode = 1'b0; i_imm = '0; i_rdest = '0; i_rsrc = '0;
    i_use_carry = 1'b0; i_set_flags = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rstReady", {31'b0, instr_ready}, 32'd1);
    checkOutput("rstRfWe", {31'b0, rf_we}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstPsr", {27'b0, psr}, 32'd0);
    checkOutput("rstRaddr", {24'b0, rf_raddr_a, rf_raddr_b}, 32'd0);
    checkOutput("rstAluAB", {alu_a, alu_b}, 32'd0);
    checkOutput("rstAluCtl", {28'b0, alu_op, alu_imm_mode, alu_carry_in, alu_update_flags} >> 0, 32'd0);
    memLoad = 1'b0;
    reset_n = 1'b1;

    // Table-driven instruction stream.
    for (int k = 0; k < 12; k++) applyStimulus(vecs[k]);
    drain();

    // instr_valid held high: one accept every fourth cycle.
    $display("[TB] handshake sequence");
    @(negedge clk);
    hv = '{4'b1101, 1'b1, 8'h55, 4'd11, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0055, 16'h0055, 1'b0, 1'b0, 5'b00011};
    i_op = hv.op; i_imm_mode = hv.immMode; i_imm = hv.imm; i_rdest = hv.rdest;
    i_rsrc = hv.rsrc; i_use_carry = hv.useCarry; i_set_flags = hv.setFlags;
    instr_valid = 1'b1;
    accepts = 0;
    for (int k = 0; k < 12; k++) begin
      checkOutput("readyPattern", {31'b0, instr_ready}, {31'b0, (k % 4) == 0});
      if (instr_ready) begin
        sbQ.push_back(toEntry(hv, cyc + 1));
        accepts++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checkOutput("acceptCount", accepts, 32'd3);
    drain();

    // Reset during EXEC aborts the instruction without side effects.
    $display("[TB] reset abort sequence");
    @(negedge clk);
    i_op = 4'b0101; i_imm_mode = 1'b1; i_imm = 8'h01; i_rdest = 4'd3; i_rsrc = 4'd0;
    i_use_carry = 1'b0; i_set_flags = 1'b1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abortReady", {31'b0, instr_ready}, 32'd1);
    checkOutput("abortPsr", {27'b0, psr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abortRfWe", {31'b0, rf_we}, 32'd0);
      checkOutput("abortDone", {31'b0, done}, 32'd0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postAbortRfWe", {31'b0, rf_we}, 32'd0);
      checkOutput("postAbortDone", {31'b0, done}, 32'd0);
      checkOutput("postAbortReady", {31'b0, instr_ready}, 32'd1);
    end
    checkOutput("abortR3Unwritten", {16'b0, mem[3]}, 32'h0006);

    // Recovery: CMP R3 with immediate 6 sets only Z.
    hv = '{4'b1011, 1'b1, 8'h06, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006, 1'b0, 1'b1, 5'b01000};
    applyStimulus(hv);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
